// File: rtl/ex_pipe.sv
// EX/MEM pipeline register for the LEGv8 five-stage pipeline.
// Captures execute results and MEM/WB control for one cycle; reset yields a bubble.
module ex_pipe #(
    parameter int DATA_W  = 64,
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32,
    parameter int REG_W   = 5
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               ZERO,
    input  logic [DATA_W-1:0]  BRANCH,
    input  logic [DATA_W-1:0]  ALU_VAL,
    input  logic [DATA_W-1:0]  RT_READ,
    input  logic [5:0]         ALU_CONTROL,
    input  logic               MEMREAD_IN,
    input  logic               MEMWRITE_IN,
    input  logic               REGWRITE_IN,
    input  logic               MEM2REG_IN,
    input  logic               BRANCH_ZERO_IN,
    input  logic [INSTR_W-1:0] INSTR_IN,
    input  logic [REG_W-1:0]   REG_DESTINATION,
    output logic [PC_W-1:0]    BRANCH_OUT,
    output logic [DATA_W-1:0]  RT_READ_OUT,
    output logic [DATA_W-1:0]  ALU_VAL_OUT,
    output logic               ZERO_OUT,
    output logic               MEMREAD_OUT,
    output logic               MEMWRITE_OUT,
    output logic               REGWRITE_OUT,
    output logic               MEM2REG_OUT,
    output logic               BRANCH_ZERO_OUT,
    output logic [REG_W-1:0]   REG_DESTINATION_OUT,
    output logic [INSTR_W-1:0] INSTR_OUT
);

    localparam int CTRL_W = 6;

    // Single-bit flags bundled so the clear/load path is uniform per bit.
    logic [CTRL_W-1:0] ctrl_in;
    logic [CTRL_W-1:0] ctrl_next;
    logic [CTRL_W-1:0] ctrl_reg;

    logic [PC_W-1:0]    branch_next,   branch_reg;
    logic [DATA_W-1:0]  rt_read_next,  rt_read_reg;
    logic [DATA_W-1:0]  alu_val_next,  alu_val_reg;
    logic [REG_W-1:0]   rd_next,       rd_reg;
    logic [INSTR_W-1:0] instr_next,    instr_reg;

    // ALU_CONTROL is not needed past EX; the branch target is truncated to PC width.
    logic unused_inputs;
    assign unused_inputs = ^{ALU_CONTROL, BRANCH[DATA_W-1:PC_W]};

    assign ctrl_in = {ZERO, MEMREAD_IN, MEMWRITE_IN, REGWRITE_IN, MEM2REG_IN, BRANCH_ZERO_IN};

    genvar gi;
    generate
        for (gi = 0; gi < CTRL_W; gi++) begin : g_ctrl
            assign ctrl_next[gi] = RESET ? 1'b0 : ctrl_in[gi];
        end
    endgenerate

    always_comb begin
        branch_next  = RESET ? '0 : BRANCH[PC_W-1:0];
        rt_read_next = RESET ? '0 : RT_READ;
        alu_val_next = RESET ? '0 : ALU_VAL;
        rd_next      = RESET ? '0 : REG_DESTINATION;
        instr_next   = RESET ? '0 : INSTR_IN;
    end

    always_ff @(posedge CLK) begin
        ctrl_reg    <= ctrl_next;
        branch_reg  <= branch_next;
        rt_read_reg <= rt_read_next;
        alu_val_reg <= alu_val_next;
        rd_reg      <= rd_next;
        instr_reg   <= instr_next;
    end

    assign ZERO_OUT            = ctrl_reg[5];
    assign MEMREAD_OUT         = ctrl_reg[4];
    assign MEMWRITE_OUT        = ctrl_reg[3];
    assign REGWRITE_OUT        = ctrl_reg[2];
    assign MEM2REG_OUT         = ctrl_reg[1];
    assign BRANCH_ZERO_OUT     = ctrl_reg[0];
    assign BRANCH_OUT          = branch_reg;
    assign RT_READ_OUT         = rt_read_reg;
    assign ALU_VAL_OUT         = alu_val_reg;
    assign REG_DESTINATION_OUT = rd_reg;
    assign INSTR_OUT           = instr_reg;

endmodule

// File: tb/tb_ex_pipe.sv
// Directed self-checking bench for the EX/MEM pipeline register.
module tb_ex_pipe;

    typedef struct {
        logic [63:0] branch;
        logic [63:0] alu_val;
        logic [63:0] rt_read;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic        zero, mr, mw, rw, m2r, bz;
    } vec_t;

    logic        clk = 1'b0;
    logic        srst;
    logic        zero;
    logic [63:0] branch, alu_val, rt_read;
    logic [5:0]  alu_control;
    logic        memread_in, memwrite_in, regwrite_in, mem2reg_in, branch_zero_in;
    logic [31:0] instr_in;
    logic [4:0]  reg_destination;

    logic [31:0] branch_out;
    logic [63:0] rt_read_out, alu_val_out;
    logic        zero_out, memread_out, memwrite_out, regwrite_out, mem2reg_out, branch_zero_out;
    logic [4:0]  reg_destination_out;
    logic [31:0] instr_out;

    int checks_total  = 0;
    int checks_passed = 0;

    always #5 clk = ~clk;

    ex_pipe dut (
        .CLK                 (clk),
        .RESET               (srst),
        .ZERO                (zero),
        .BRANCH              (branch),
        .ALU_VAL             (alu_val),
        .RT_READ             (rt_read),
        .ALU_CONTROL         (alu_control),
        .MEMREAD_IN          (memread_in),
        .MEMWRITE_IN         (memwrite_in),
        .REGWRITE_IN         (regwrite_in),
        .MEM2REG_IN          (mem2reg_in),
        .BRANCH_ZERO_IN      (branch_zero_in),
        .INSTR_IN            (instr_in),
        .REG_DESTINATION     (reg_destination),
        .BRANCH_OUT          (branch_out),
        .RT_READ_OUT         (rt_read_out),
        .ALU_VAL_OUT         (alu_val_out),
        .ZERO_OUT            (zero_out),
        .MEMREAD_OUT         (memread_out),
        .MEMWRITE_OUT        (memwrite_out),
        .REGWRITE_OUT        (regwrite_out),
        .MEM2REG_OUT         (mem2reg_out),
        .BRANCH_ZERO_OUT     (branch_zero_out),
        .REG_DESTINATION_OUT (reg_destination_out),
        .INSTR_OUT           (instr_out)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_total++;
        if (obs === exp) checks_passed++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic apply(input vec_t v);
        branch = v.branch;  alu_val = v.alu_val;  rt_read = v.rt_read;
        instr_in = v.instr; reg_destination = v.rd;
        zero = v.zero; memread_in = v.mr; memwrite_in = v.mw;
        regwrite_in = v.rw; mem2reg_in = v.m2r; branch_zero_in = v.bz;
    endtask

    // Expected register image of a vector: identity except branch truncated to 32 bits.
    task automatic expect_vec(input string tag, input vec_t v);
        logic [31:0] br_lo;
        br_lo = v.branch[31:0];
        check({tag, ".branch"}, {32'h0, branch_out}, {32'h0, br_lo});
        check({tag, ".alu"},    alu_val_out, v.alu_val);
        check({tag, ".rt"},     rt_read_out, v.rt_read);
        check({tag, ".instr"},  {32'h0, instr_out}, {32'h0, v.instr});
        check({tag, ".rd"},     {59'h0, reg_destination_out}, {59'h0, v.rd});
        check({tag, ".ctrl"},
              {58'h0, zero_out, memread_out, memwrite_out, regwrite_out, mem2reg_out, branch_zero_out},
              {58'h0, v.zero, v.mr, v.mw, v.rw, v.m2r, v.bz});
        $display("txn %s: instr=%h alu=%h rd=%0d", tag, instr_out, alu_val_out, reg_destination_out);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t ones, zeros, v_a, v_b, v_br;
    vec_t stream [4];

    initial begin
        ones  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                  32'hFFFF_FFFF, 5'h1F, 1, 1, 1, 1, 1, 1};
        zeros = '{64'h0, 64'h0, 64'h0, 32'h0, 5'h0, 0, 0, 0, 0, 0, 0};
        v_a   = '{64'h0, 64'h28, 64'h1234, 32'hF800_0000, 5'd3, 0, 0, 1, 0, 0, 0};
        v_b   = '{64'h100, 64'h30, 64'h5555, 32'h8B00_0000, 5'd7, 0, 0, 0, 1, 0, 0};
        v_br  = '{64'hDEAD_BEEF_0000_0040, 64'h0, 64'h0, 32'hB400_0000, 5'd0, 1, 0, 0, 0, 0, 1};
        stream[0] = '{64'h10, 64'h40, 64'h0,  32'hF840_0000, 5'd1, 0, 1, 0, 1, 1, 0};
        stream[1] = '{64'h20, 64'h48, 64'h99, 32'hF800_0000, 5'd2, 0, 0, 1, 0, 0, 0};
        stream[2] = '{64'h30, 64'h7,  64'h3,  32'h8B00_0000, 5'd4, 0, 0, 0, 1, 0, 0};
        stream[3] = '{64'h1_0000_0080, 64'h0, 64'h0, 32'hB400_0000, 5'd9, 1, 0, 0, 0, 0, 1};

        alu_control = 6'h2A;
        srst = 1'b1;
        apply(ones);
        #2;
        tick();
        expect_vec("reset", zeros);

        srst = 1'b0;
        tick();
        expect_vec("post_reset", ones);
        check("post_reset.alu_const", alu_val_out, 64'hFFFF_FFFF_FFFF_FFFF);
        check("post_reset.rd_const", {59'h0, reg_destination_out}, 64'h1F);

        // Latency: new inputs must not show until the next edge.
        apply(v_a);
        #2;
        expect_vec("latency_before", ones);
        tick();
        expect_vec("latency_after", v_a);
        check("latency.mw", {63'h0, memwrite_out}, 64'h1);
        #3;
        apply(v_b);
        #2;
        expect_vec("midcycle_hold", v_a);
        tick();
        expect_vec("midcycle_next", v_b);

        apply(v_br);
        tick();
        expect_vec("branch_trunc", v_br);
        check("branch_trunc.const", {32'h0, branch_out}, 64'h0000_0040);
        check("branch_trunc.flags", {62'h0, zero_out, branch_zero_out}, 64'h3);

        for (int i = 0; i < 4; i++) begin
            apply(stream[i]);
            tick();
            expect_vec($sformatf("stream%0d", i), stream[i]);
        end

        // Reset asserted for the third item only.
        for (int i = 0; i < 4; i++) begin
            apply(stream[i]);
            srst = (i == 2);
            tick();
            if (i == 2) expect_vec("midrst_zero", zeros);
            else        expect_vec($sformatf("midrst%0d", i), stream[i]);
        end
        srst = 1'b0;

        apply(v_a);
        tick();
        for (int c = 0; c < 64; c++) begin
            alu_control = c[5:0];
            tick();
            check($sformatf("aluctl%0d.alu", c), alu_val_out, 64'h28);
            check($sformatf("aluctl%0d.misc", c),
                  {rt_read_out[31:0], instr_out[31:27], reg_destination_out, memwrite_out, regwrite_out},
                  {32'h1234, 5'h1F, 5'd3, 1'b1, 1'b0});
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
